// File: rtl/rota_pkg.sv
// Shared constants for the route-code serial transmitter: legal codes,
// frame line levels and FSM state encoding.
package rota_pkg;

    localparam logic [5:0] ROTA_0 = 6'b111000;
    localparam logic [5:0] ROTA_1 = 6'b100011;
    localparam logic [5:0] ROTA_2 = 6'b100101;
    localparam logic [5:0] ROTA_3 = 6'b100110;

    localparam logic START_SEVIYE = 1'b0;
    localparam logic STOP_SEVIYE  = 1'b1;
    localparam int   VERI_BIT     = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } durum_t;

endpackage

// File: rtl/rota_kodlayici.sv
// Maps a 2-bit route selector onto one of the four codes the route checker
// accepts. Purely combinational.
module rota_kodlayici
    import rota_pkg::*;
(
    input  logic [1:0] i_rota_sec,
    output logic [5:0] o_kod
);

    always_comb begin
        o_kod = ROTA_0;
        case (i_rota_sec)
            2'd0: o_kod = ROTA_0;
            2'd1: o_kod = ROTA_1;
            2'd2: o_kod = ROTA_2;
            2'd3: o_kod = ROTA_3;
            default: o_kod = ROTA_0;
        endcase
    end

endmodule

// File: rtl/rota_verici.sv
// Framed serial transmitter for route codes: start bit, 6 data bits MSB first,
// stop bit, each held BIT_CYCLES clocks, with ready/start handshake.
module rota_verici
    import rota_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       gonder,
    input  logic [1:0] rota_sec,
    output logic       hazir,
    output logic       mesgul,
    output logic       seri_cikis,
    output logic       bitti,
    output logic [5:0] rota_kodu
);

    localparam logic [7:0] CYC_SON = 8'(BIT_CYCLES - 1);
    localparam logic [2:0] BIT_SON = 3'(VERI_BIT - 1);

    durum_t     r_durum;
    logic [7:0] r_cyc;
    logic [2:0] r_bit;
    logic [5:0] r_shift;
    logic [5:0] r_kod;
    logic       r_seri;
    logic       r_bitti;
    logic       r_hazir;

    logic [5:0] w_kod;
    logic       w_son;

    rota_kodlayici u_kodlayici (
        .i_rota_sec (rota_sec),
        .o_kod      (w_kod)
    );

    assign w_son = (r_cyc == CYC_SON);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_durum <= S_IDLE;
            r_cyc   <= 8'd0;
            r_bit   <= 3'd0;
            r_shift <= 6'd0;
            r_kod   <= 6'd0;
            r_seri  <= STOP_SEVIYE;
            r_bitti <= 1'b0;
            r_hazir <= 1'b1;
        end else begin
            r_bitti <= 1'b0;
            case (r_durum)
                S_IDLE: begin
                    if (gonder) begin
                        r_kod   <= w_kod;
                        r_shift <= w_kod;
                        r_seri  <= START_SEVIYE;
                        r_hazir <= 1'b0;
                        r_cyc   <= 8'd0;
                        r_bit   <= 3'd0;
                        r_durum <= S_START;
                    end
                end
                S_START: begin
                    if (w_son) begin
                        r_cyc   <= 8'd0;
                        r_bit   <= 3'd0;
                        r_seri  <= r_shift[5];
                        r_shift <= {r_shift[4:0], 1'b0};
                        r_durum <= S_DATA;
                    end else begin
                        r_cyc <= r_cyc + 8'd1;
                    end
                end
                S_DATA: begin
                    if (w_son) begin
                        r_cyc <= 8'd0;
                        if (r_bit == BIT_SON) begin
                            r_seri  <= STOP_SEVIYE;
                            r_durum <= S_STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_seri  <= r_shift[5];
                            r_shift <= {r_shift[4:0], 1'b0};
                        end
                    end else begin
                        r_cyc <= r_cyc + 8'd1;
                    end
                end
                S_STOP: begin
                    // Ready again in the bitti cycle so a new request can be taken at once.
                    if (w_son) begin
                        r_cyc   <= 8'd0;
                        r_bitti <= 1'b1;
                        r_hazir <= 1'b1;
                        r_durum <= S_IDLE;
                    end else begin
                        r_cyc <= r_cyc + 8'd1;
                    end
                end
                default: r_durum <= S_IDLE;
            endcase
        end
    end

    assign hazir      = r_hazir;
    assign mesgul     = ~r_hazir;
    assign seri_cikis = r_seri;
    assign bitti      = r_bitti;
    assign rota_kodu  = r_kod;

endmodule

// File: tb/tb_rota_verici.sv
// Bench for rota_verici: two instances (BIT_CYCLES=4 and 1), a frame-timing
// model checked every cycle, plus directed frames with literal expectations.
module tb_rota_verici;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       gonder [2];
    logic [1:0] sel [2];
    logic       hazir [2];
    logic       mesgul [2];
    logic       seri [2];
    logic       bitti [2];
    logic [5:0] kod [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rota_verici #(.BIT_CYCLES(4)) u_a (
        .clk(clk), .rst_n(rst_n), .gonder(gonder[0]), .rota_sec(sel[0]),
        .hazir(hazir[0]), .mesgul(mesgul[0]), .seri_cikis(seri[0]),
        .bitti(bitti[0]), .rota_kodu(kod[0])
    );

    rota_verici #(.BIT_CYCLES(1)) u_b (
        .clk(clk), .rst_n(rst_n), .gonder(gonder[1]), .rota_sec(sel[1]),
        .hazir(hazir[1]), .mesgul(mesgul[1]), .seri_cikis(seri[1]),
        .bitti(bitti[1]), .rota_kodu(kod[1])
    );

    function automatic int bc(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic logic [5:0] kod_map(input logic [1:0] s);
        logic [5:0] t [4];
        t[0] = 6'b111000; t[1] = 6'b100011; t[2] = 6'b100101; t[3] = 6'b100110;
        return t[s];
    endfunction

    // Receiving-end acceptance rule of the route checker.
    function automatic logic rotadogrula(input logic [5:0] c);
        return (c == 6'b111000) || (c == 6'b100011) || (c == 6'b100101) || (c == 6'b100110);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: a frame is "edges since accept"; the line level follows from k / BIT_CYCLES.
    bit         m_busy [2];
    bit         m_bitti [2];
    int         m_k [2];
    logic [5:0] m_kod [2] = '{6'd0, 6'd0};

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_busy[d] = 0; m_bitti[d] = 0; m_k[d] = 0; m_kod[d] = 6'd0;
            end else if (m_busy[d]) begin
                m_k[d]++;
                m_bitti[d] = (m_k[d] == 8 * bc(d));
                if (m_bitti[d]) m_busy[d] = 0;
            end else begin
                m_bitti[d] = 0;
                if (gonder[d]) begin
                    m_busy[d] = 1; m_k[d] = 0; m_kod[d] = kod_map(sel[d]);
                end
            end
        end
    end

    function automatic logic exp_seri(input int d);
        int idx;
        if (!m_busy[d]) return 1'b1;
        idx = m_k[d] / bc(d);
        if (idx == 0) return 1'b0;
        if (idx <= 6) return m_kod[d][6 - idx];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("hazir%0d", d), 32'(hazir[d]), 32'(!m_busy[d]));
            chk($sformatf("mesgul%0d", d), 32'(mesgul[d]), 32'(m_busy[d]));
            chk($sformatf("seri%0d", d), 32'(seri[d]), 32'(exp_seri(d)));
            chk($sformatf("bitti%0d", d), 32'(bitti[d]), 32'(m_bitti[d]));
            chk($sformatf("kod%0d", d), 32'(kod[d]), 32'(m_kod[d]));
        end
    end

    // Sends one frame and samples bit centres; bits = {start, d5..d0, stop}.
    task automatic run_frame(input int d, input logic [1:0] s, input int poke,
                             output logic [7:0] bits, output int lat, output int pulses);
        int n;
        n = bc(d);
        @(posedge clk); #1; gonder[d] = 1'b1; sel[d] = s;
        @(posedge clk); #1; gonder[d] = 1'b0;
        bits = 8'd0; lat = -1; pulses = 0;
        for (int c = 0; c < 8 * n + 4; c++) begin
            if (c < 8 * n && (c % n) == n / 2) bits = {bits[6:0], seri[d]};
            if (bitti[d]) begin
                pulses++;
                if (lat < 0) lat = c;
            end
            if (c == poke) begin gonder[d] = 1'b1; sel[d] = 2'd2; end
            else if (c == poke + 1) gonder[d] = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    logic [7:0] bits;
    int         lat, pulses, lows;
    logic       s4 [80];
    logic       b4 [80];
    logic [7:0] f1, f2;
    logic [5:0] exp_codes [4];

    initial begin
        exp_codes[0] = 6'b111000; exp_codes[1] = 6'b100011;
        exp_codes[2] = 6'b100101; exp_codes[3] = 6'b100110;
        gonder[0] = 1'b0; gonder[1] = 1'b0; sel[0] = 2'd0; sel[1] = 2'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hazir", 32'(hazir[0]), 32'd1);
        chk("rst_seri", 32'(seri[0]), 32'd1);
        chk("rst_kod", 32'(kod[0]), 32'd0);
        chk("rst_bitti", 32'(bitti[0]), 32'd0);
        rst_n = 1'b1;

        // Selector 1 at 4 cycles per bit.
        run_frame(0, 2'd1, -10, bits, lat, pulses);
        chk("t1_bits", 32'(bits), 32'(8'b01000111));
        chk("t1_lat", 32'(lat), 32'd32);
        chk("t1_pulses", 32'(pulses), 32'd1);
        chk("t1_kod", 32'(kod[0]), 32'(6'b100011));

        // All selectors through the receiving-side check.
        for (int s = 0; s < 4; s++) begin
            run_frame(0, 2'(s), -10, bits, lat, pulses);
            chk($sformatf("t2_code%0d", s), 32'(bits[6:1]), 32'(exp_codes[s]));
            chk($sformatf("t2_dogru%0d", s), 32'(rotadogrula(bits[6:1])), 32'd1);
            chk($sformatf("t2_frame%0d", s), 32'({bits[7], bits[0]}), 32'(2'b01));
        end

        // Request during data bit d0 is ignored, not queued.
        run_frame(0, 2'd0, 25, bits, lat, pulses);
        chk("t3_bits", 32'(bits), 32'(8'b01110001));
        chk("t3_pulses", 32'(pulses), 32'd1);
        lows = 0;
        for (int c = 0; c < 40; c++) begin
            if (seri[0] == 1'b0) lows++;
            @(posedge clk); #1;
        end
        chk("t3_no_second", 32'(lows), 32'd0);

        // gonder held high: two contiguous frames, selector changed mid-frame.
        @(posedge clk); #1; gonder[0] = 1'b1; sel[0] = 2'd3;
        @(posedge clk); #1;
        for (int c = 0; c < 80; c++) begin
            s4[c] = seri[0]; b4[c] = bitti[0];
            if (c == 5) sel[0] = 2'd0;
            if (c == 33) gonder[0] = 1'b0;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 8; i++) begin
            f1[7 - i] = s4[2 + 4 * i];
            f2[7 - i] = s4[35 + 4 * i];
        end
        chk("t4_frame1", 32'(f1), 32'(8'b01001101));
        chk("t4_frame2", 32'(f2), 32'(8'b01110001));
        chk("t4_bitti1", 32'(b4[32]), 32'd1);
        chk("t4_bitti2", 32'(b4[65]), 32'd1);
        chk("t4_gap_high", 32'(s4[32]), 32'd1);
        chk("t4_start2", 32'(s4[33]), 32'd0);

        // Asynchronous reset in the middle of a data bit.
        @(posedge clk); #1; gonder[0] = 1'b1; sel[0] = 2'd3;
        @(posedge clk); #1; gonder[0] = 1'b0;
        repeat (13) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_seri", 32'(seri[0]), 32'd1);
        chk("t5_hazir", 32'(hazir[0]), 32'd1);
        chk("t5_mesgul", 32'(mesgul[0]), 32'd0);
        chk("t5_kod", 32'(kod[0]), 32'd0);
        chk("t5_bitti", 32'(bitti[0]), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        run_frame(0, 2'd2, -10, bits, lat, pulses);
        chk("t5_after_bits", 32'(bits), 32'(8'b01001011));
        chk("t5_after_lat", 32'(lat), 32'd32);

        // One cycle per bit.
        run_frame(1, 2'd0, -10, bits, lat, pulses);
        chk("t6_bits", 32'(bits), 32'(8'b01110001));
        chk("t6_lat", 32'(lat), 32'd8);
        chk("t6_pulses", 32'(pulses), 32'd1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
